// File: rtl/grant_xfer_ctrl_if.sv
// grant_xfer_ctrl_if: arbiter grants, client start addresses and shared burst bus of grant_xfer_ctrl.
// err_both exists only when GRANT_CHECK_EN is defined.
interface grant_xfer_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 3
);
  logic              gnt_0;
  logic              gnt_1;
  logic [ADDR_W-1:0] addr_0;
  logic [ADDR_W-1:0] addr_1;
  logic              bus_ready;
  logic              bus_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_owner;
  logic              busy;
  logic [CNT_W-1:0]  beat_cnt;
  logic              done_0;
  logic              done_1;
`ifdef GRANT_CHECK_EN
  logic              err_both;
`endif
  modport master (
    input  gnt_0, gnt_1, addr_0, addr_1, bus_ready,
    output bus_valid, bus_addr, bus_owner, busy, beat_cnt, done_0, done_1
`ifdef GRANT_CHECK_EN
    , output err_both
`endif
  );
  modport slave (
    output gnt_0, gnt_1, addr_0, addr_1, bus_ready,
    input  bus_valid, bus_addr, bus_owner, busy, beat_cnt, done_0, done_1
`ifdef GRANT_CHECK_EN
    , input err_both
`endif
  );
endinterface

// File: rtl/grant_xfer_ctrl.sv
// grant_xfer_ctrl: turns an arbiter grant into a fixed-length valid/ready address burst for the winning client.
// GRANT_CHECK_EN: when defined, simultaneous grants in IDLE raise err_both instead of starting a burst.
module grant_xfer_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input logic               i_clk,
  input logic               i_rst_n,
  grant_xfer_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [CNT_W-1:0]  r_cnt, w_cnt, w_cnt_inc;
  logic              r_valid, w_valid;
  logic              r_owner, w_owner;
  logic              r_busy, w_busy;
  logic              r_done_0, w_done_0;
  logic              r_done_1, w_done_1;
  logic              w_start;
`ifdef GRANT_CHECK_EN
  logic              r_err, w_err;
  assign w_start = bus.gnt_0 ^ bus.gnt_1;
  assign w_err   = (r_state == IDLE) & bus.gnt_0 & bus.gnt_1;
  assign bus.err_both = r_err;
`else
  assign w_start = bus.gnt_0 | bus.gnt_1;
`endif
  assign w_cnt_inc = r_cnt + 1'b1;
  always_comb begin
    w_state  = r_state;
    w_addr   = r_addr;
    w_cnt    = r_cnt;
    w_valid  = r_valid;
    w_owner  = r_owner;
    w_busy   = r_busy;
    w_done_0 = 1'b0;
    w_done_1 = 1'b0;
    case (r_state)
      IDLE: if (w_start) begin
        w_owner = ~bus.gnt_0;
        w_addr  = bus.gnt_0 ? bus.addr_0 : bus.addr_1;
        w_cnt   = '0;
        w_busy  = 1'b1;
        w_valid = 1'b1;
        w_state = XFER;
      end
      XFER: if (r_valid && bus.bus_ready) begin
        w_cnt  = w_cnt_inc;
        w_addr = r_addr + 1'b1;
        if (w_cnt_inc == CNT_W'(BURST_LEN)) begin
          w_valid  = 1'b0;
          w_state  = DONE;
          w_done_0 = ~r_owner;
          w_done_1 = r_owner;
        end
      end
      DONE: begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_cnt   = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_owner  <= 1'b0;
      r_busy   <= 1'b0;
      r_done_0 <= 1'b0;
      r_done_1 <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_addr   <= w_addr;
      r_cnt    <= w_cnt;
      r_valid  <= w_valid;
      r_owner  <= w_owner;
      r_busy   <= w_busy;
      r_done_0 <= w_done_0;
      r_done_1 <= w_done_1;
    end
  end
`ifdef GRANT_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_err <= 1'b0;
    else          r_err <= w_err;
  end
`endif
  assign bus.bus_valid = r_valid;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_owner = r_owner;
  assign bus.busy      = r_busy;
  assign bus.beat_cnt  = r_cnt;
  assign bus.done_0    = r_done_0;
  assign bus.done_1    = r_done_1;
endmodule

// File: tb/tb_grant_xfer_ctrl.sv
// tb_grant_xfer_ctrl: directed and randomized bursts checked against a transaction-level model
// (expected beat address = start address + accepted beats, owner from the grant rule).
module tb_grant_xfer_ctrl;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 3;
  localparam int BL     = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  grant_xfer_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_if ();
  grant_xfer_ctrl #(.ADDR_W(ADDR_W), .BURST_LEN(BL), .CNT_W(CNT_W)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(u_if)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, u_if.bus_valid, 0);
    chk({tag, "_busy"}, u_if.busy, 0);
    chk({tag, "_cnt"}, u_if.beat_cnt, 0);
    chk({tag, "_done0"}, u_if.done_0, 0);
    chk({tag, "_done1"}, u_if.done_1, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk_idle(tag);
    chk({tag, "_addr"}, u_if.bus_addr, 0);
    chk({tag, "_owner"}, u_if.bus_owner, 0);
`ifdef GRANT_CHECK_EN
    chk({tag, "_err"}, u_if.err_both, 0);
`endif
  endtask
  // mode 0: ready always high; 1: random ready; 2: ready low for two cycles once two beats are in
  task automatic run_burst(input bit g0, input bit g1, input logic [7:0] a0, input logic [7:0] a1,
                           input int mode);
    int         beats;
    int         cyc;
    int         stall;
    bit         rdy;
    bit         own;
    logic [7:0] base;
    logic [7:0] ea;
    u_if.gnt_0 = g0;
    u_if.gnt_1 = g1;
    u_if.addr_0 = a0;
    u_if.addr_1 = a1;
    u_if.bus_ready = 1'($urandom_range(0, 1));
    step;
`ifdef GRANT_CHECK_EN
    if (g0 && g1) begin
      chk("both_err", u_if.err_both, 1);
      chk("both_valid", u_if.bus_valid, 0);
      chk("both_busy", u_if.busy, 0);
      u_if.gnt_0 = 1'b0;
      u_if.gnt_1 = 1'b0;
      step;
      chk("both_err_pulse", u_if.err_both, 0);
      chk("both_valid2", u_if.bus_valid, 0);
      return;
    end
`endif
    own = !g0;
    base = own ? a1 : a0;
    beats = 0;
    cyc = 0;
    stall = 0;
    while (beats < BL && cyc < 100) begin
      ea = base + 8'(beats);
      chk("xfer_valid", u_if.bus_valid, 1);
      chk("xfer_addr", u_if.bus_addr, ea);
      chk("xfer_cnt", u_if.beat_cnt, beats);
      chk("xfer_busy", u_if.busy, 1);
      chk("xfer_owner", u_if.bus_owner, own);
      chk("xfer_done0", u_if.done_0, 0);
      chk("xfer_done1", u_if.done_1, 0);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else rdy = !(beats == 2 && stall < 2);
      if (!rdy) stall++;
      u_if.bus_ready = rdy;
      u_if.gnt_0 = 1'($urandom_range(0, 1));
      u_if.gnt_1 = 1'($urandom_range(0, 1));
      u_if.addr_0 = 8'($urandom);
      u_if.addr_1 = 8'($urandom);
      step;
      cyc++;
      if (rdy) beats++;
    end
    chk("burst_beats", beats, BL);
    if (mode == 0) chk("burst_cycles", cyc, BL);
    if (mode == 2) chk("stall_cycles", cyc, BL + 2);
    chk("done_valid", u_if.bus_valid, 0);
    chk("done_busy", u_if.busy, 1);
    chk("done_owner", u_if.bus_owner, own);
    chk("done_cnt", u_if.beat_cnt, BL);
    chk("done_pulse0", u_if.done_0, !own);
    chk("done_pulse1", u_if.done_1, own);
    u_if.gnt_0 = 1'b0;
    u_if.gnt_1 = 1'b0;
    u_if.bus_ready = 1'($urandom_range(0, 1));
    step;
    chk_idle("post_done");
  endtask
  initial begin
    bit g0;
    bit g1;
    u_if.gnt_0 = 1'b0;
    u_if.gnt_1 = 1'b0;
    u_if.addr_0 = '0;
    u_if.addr_1 = '0;
    u_if.bus_ready = 1'b0;
    rst_n = 1'b0;
    step;
    step;
    chk_zero("reset");
    rst_n = 1'b1;
    step;
    chk_idle("idle0");
    u_if.bus_ready = 1'b1;
    step;
    chk_idle("idle1");
    run_burst(1'b1, 1'b0, 8'h10, 8'h55, 0);
    run_burst(1'b0, 1'b1, 8'h33, 8'hFE, 0);
    run_burst(1'b1, 1'b0, 8'h40, 8'h00, 2);
    // reset after two accepted beats: outputs clear immediately and no done pulse follows
    u_if.gnt_0 = 1'b1;
    u_if.addr_0 = 8'h80;
    step;
    u_if.gnt_0 = 1'b0;
    u_if.bus_ready = 1'b1;
    step;
    step;
    chk("pre_reset_cnt", u_if.beat_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (3) begin
      step;
      chk_zero("hold_reset");
    end
    rst_n = 1'b1;
    repeat (4) begin
      step;
      chk_idle("after_reset");
    end
    run_burst(1'b1, 1'b1, 8'h20, 8'h90, 0);
    for (int i = 0; i < 40; i++) begin
      g0 = 1'($urandom_range(0, 1));
      g1 = g0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_burst(g0, g1, 8'($urandom), 8'($urandom), 1);
      repeat ($urandom_range(0, 2)) begin
        step;
        chk_idle("gap");
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
